reset_sequencer_staged: RTL and testbench
=========================================

Name: reset_sequencer_staged

Overview:
- Parametrised power-on and runtime reset sequencer for one clock domain.
- Holds NCH reset outputs asserted until the PLL is locked and a sanity hold count has expired. It then releases the outputs in stages (bit 0 first), spaced STAGE_GAP cycles apart.
- Re-asserts all outputs on PLL lock loss, a debounced external button or a software request, and records the reset cause.
- Instantiated once per clock domain in board top units. It replaces per-domain reset flops that had a fixed sanity count and no lock monitoring or staging.

Parameters:
- NCH, 6, number of staged reset outputs (1..16).
- HOLD_W, 16, width of the hold counter.
- HOLD_CYCLES, 43605, consecutive locked cycles required before the first release (1..2^HOLD_W-1).
- STAGE_GAP, 4, cycles between successive output releases (1..255).
- DEB_CYCLES, 8, consecutive stable samples needed for the debounced button level to change (1..255).

Ports:
- clock  in  1  domain clock.
- reset  in  1  asynchronous, active-low reset.
- pllLocked  in  1  PLL lock, asynchronous; synchronised internally by a 2-flop synchroniser.
- extResetReq  in  1  board button, active-high, asynchronous; 2-flop synchroniser, then debounce.
- swResetReq  in  1  synchronous single-cycle request pulse.
- rstOut  out  NCH  active-high resets; 1 = held in reset.
- rstReady  out  1  1 when all rstOut bits are released.
- rstCause  out  4  bit0 POR, bit1 PLL loss, bit2 button, bit3 software.
- stateOut  out  2  0 = HOLD, 1 = RELEASE, 2 = RUN.

Behaviour:
- Async reset (reset=0):
  - state=HOLD, holdCnt=0, gapCnt=0, stage=0.
  - rstOut all 1, rstReady=0, rstCause=4'b0001.
  - Synchroniser flops and debounced level reset to 0; debounce counter reset to 0.
- Synchronisers: a change on pllLocked or extResetReq is visible internally after 2 edges.
- Debounce:
  - The counter increments while the synchronised button differs from the debounced level.
  - It clears when they match.
  - On reaching DEB_CYCLES-1 while still differing, the debounced level toggles and the counter clears.
- Request term req = !pllSync | btnDeb | swResetReq. It is evaluated every cycle in every state.
- HOLD:
  - If req: holdCnt <= 0, and the cause bits of all active sources are ORed into rstCause.
  - Else holdCnt increments.
  - At an edge where holdCnt==HOLD_CYCLES-1 and !req:
    - go to RELEASE, clear rstOut[0], set gapCnt=0 and stage=1;
    - if NCH==1, go straight to RUN and set rstReady=1.
- RELEASE:
  - gapCnt increments each cycle.
  - When gapCnt==STAGE_GAP-1: clear rstOut[stage], stage++, gapCnt=0.
  - The edge that clears rstOut[NCH-1] also sets state=RUN and rstReady=1.
- RUN: outputs are stable until req.
- Entry from RELEASE or RUN on req takes one edge:
  - all rstOut=1, rstReady=0, state=HOLD, holdCnt=0;
  - rstCause is REPLACED by the active-source bits (bit0 is then 0).
- Simultaneous sources: all active bits are set together.
- A software pulse arriving while in HOLD restarts the hold count.
- Button held: the block stays in HOLD for as long as the debounced level is 1.
- rstCause is stable during RELEASE and RUN; software reads it after release.
- Released outputs never re-assert individually: re-assertion is always all-at-once.
- Async reset mid-sequence overrides everything immediately, without waiting for a clock edge.
- No output glitches: all outputs are registered.

Test Plan:
Bench overrides for all scenarios: NCH=3, HOLD_CYCLES=8, STAGE_GAP=2, DEB_CYCLES=4.

1. Power-on with pllLocked=1 constant; release reset before edge 1:
   - rstOut=3'b111 through edge 9;
   - rstOut[0]=0 at edge 10, rstOut[1]=0 at edge 12, rstOut[2]=0 at edge 14;
   - rstReady=1 at edge 14, rstCause=0001.
2. In RUN, drop pllLocked at edge N:
   - rstOut=111, rstReady=0, stateOut=0 and rstCause=0010 at edge N+2;
   - restore lock: release sequence repeats with the same 10/12/14 spacing, measured relative to the restore edge.
3. In RUN, pulse swResetReq for 1 cycle:
   - next edge: rstOut=111, rstCause=1000;
   - rstOut[0] clears 8 edges later.
4. In RUN, drive extResetReq as 1-0-1 with 2-cycle glitches:
   - no reset occurs;
   - a 4+ cycle steady high re-asserts rstOut at sync(2)+debounce(4) edges, rstCause=0100, and the block stays in HOLD while held.
5. PLL loss and swResetReq on the same cycle during RELEASE (after rstOut[0] released):
   - rstOut returns to 111, rstCause=1010, holdCnt restarts from 0.
6. Assert reset low during RELEASE, between clock edges:
   - rstOut=111, rstReady=0 and rstCause=0001 immediately;
   - the sequence restarts from scratch after reset is released.

Source files
------------

// File: rtl/reset_sequencer_staged_if.sv
// Reset sequencer signal bundle.
//
// Groups the request inputs and reset/status outputs of reset_sequencer_staged so board tops
// can pass one bundle per clock domain. Clock and reset stay plain ports on the module.
//
//   pllLocked    PLL lock, asynchronous (synchronised inside the sequencer)
//   extResetReq  board button, active-high, asynchronous (synchronised and debounced inside)
//   swResetReq   synchronous single-cycle software reset request
//   rstOut       NCH active-high staged resets, 1 = held in reset
//   rstReady     1 once every rstOut bit is released
//   rstCause     bit0 POR, bit1 PLL loss, bit2 button, bit3 software
//   stateOut     0 = HOLD, 1 = RELEASE, 2 = RUN
//
// modport master: the sequencer side (drives resets and status).
// modport slave:  the environment side (drives requests, consumes resets).
interface reset_sequencer_staged_if #(
    parameter int unsigned NCH = 6
);
    logic           pllLocked;
    logic           extResetReq;
    logic           swResetReq;
    logic [NCH-1:0] rstOut;
    logic           rstReady;
    logic [3:0]     rstCause;
    logic [1:0]     stateOut;

    modport master (
        input  pllLocked,
        input  extResetReq,
        input  swResetReq,
        output rstOut,
        output rstReady,
        output rstCause,
        output stateOut
    );

    modport slave (
        output pllLocked,
        output extResetReq,
        output swResetReq,
        input  rstOut,
        input  rstReady,
        input  rstCause,
        input  stateOut
    );
endinterface

// File: rtl/reset_sequencer_staged.sv
// Staged power-on / runtime reset sequencer for one clock domain.
//
// Holds NCH resets asserted until the PLL is locked and HOLD_CYCLES consecutive request-free
// cycles have passed, then releases them one at a time (bit 0 first) every STAGE_GAP cycles.
// PLL lock loss, a debounced button or a software pulse re-asserts all outputs at once and
// records which sources were active in rstCause.
//
// Ports:
//   clock   domain clock
//   reset   asynchronous active-low reset
//   bus     reset_sequencer_staged_if.master (requests in, rstOut/rstReady/rstCause/stateOut out)
//
// The interface instance must be built with the same NCH as this module.
module reset_sequencer_staged #(
    parameter int unsigned NCH         = 6,
    parameter int unsigned HOLD_W      = 16,
    parameter int unsigned HOLD_CYCLES = 43605,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned DEB_CYCLES  = 8
) (
    input logic                      clock,
    input logic                      reset,
    reset_sequencer_staged_if.master bus
);

    localparam int unsigned       StageW    = $clog2(NCH + 1);
    localparam logic [HOLD_W-1:0] HoldLast  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [7:0]        GapLast   = 8'(STAGE_GAP - 1);
    localparam logic [7:0]        DebLast   = 8'(DEB_CYCLES - 1);
    localparam logic [StageW-1:0] StageLast = StageW'(NCH - 1);
    localparam logic [NCH-1:0]    OneBit    = NCH'(1);

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2
    } state_e;

    // Synchronisers and debounce
    logic       pll_meta_q, pll_meta_d;
    logic       pll_sync_q, pll_sync_d;
    logic       btn_meta_q, btn_meta_d;
    logic       btn_sync_q, btn_sync_d;
    logic       btn_deb_q, btn_deb_d;
    logic [7:0] deb_cnt_q, deb_cnt_d;
    logic       pll_seen_q, pll_seen_d;

    // Sequencer
    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic [StageW-1:0] stage_q, stage_d;
    logic [NCH-1:0]    rst_out_q, rst_out_d;
    logic              rst_ready_q, rst_ready_d;
    logic [3:0]        rst_cause_q, rst_cause_d;

    logic       pll_lost;
    logic       req;
    logic [3:0] src_cause;

    always_comb begin
        pll_meta_d = bus.pllLocked;
        pll_sync_d = pll_meta_q;
        btn_meta_d = bus.extResetReq;
        btn_sync_d = btn_meta_q;
        pll_seen_d = pll_seen_q | pll_sync_q;
    end

    // Debounce: the level flips only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        btn_deb_d = btn_deb_q;
        deb_cnt_d = deb_cnt_q;
        if (btn_sync_q == btn_deb_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
            btn_deb_d = ~btn_deb_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 8'd1;
        end
    end

    assign pll_lost = ~pll_sync_q;
    assign req      = pll_lost | btn_deb_q | bus.swResetReq;

    // Waiting for the first lock after power-on is not a lock loss, so the PLL cause bit is
    // only recorded once lock has been seen at least once since reset.
    assign src_cause = {bus.swResetReq, btn_deb_q, pll_lost & pll_seen_q, 1'b0};

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        stage_d     = stage_q;
        rst_out_d   = rst_out_q;
        rst_ready_d = rst_ready_q;
        rst_cause_d = rst_cause_q;

        unique case (state_q)
            StHold: begin
                if (req) begin
                    hold_cnt_d  = '0;
                    rst_cause_d = rst_cause_q | src_cause;
                end else if (hold_cnt_q == HoldLast) begin
                    hold_cnt_d   = '0;
                    rst_out_d[0] = 1'b0;
                    gap_cnt_d    = '0;
                    stage_d      = StageW'(1);
                    if (NCH == 1) begin
                        state_d     = StRun;
                        rst_ready_d = 1'b1;
                    end else begin
                        state_d = StRelease;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            StRelease: begin
                if (req) begin
                    state_d     = StHold;
                    hold_cnt_d  = '0;
                    rst_out_d   = '1;
                    rst_ready_d = 1'b0;
                    rst_cause_d = src_cause;
                end else if (gap_cnt_q == GapLast) begin
                    rst_out_d = rst_out_q & ~(OneBit << stage_q);
                    gap_cnt_d = '0;
                    stage_d   = stage_q + StageW'(1);
                    if (stage_q == StageLast) begin
                        state_d     = StRun;
                        rst_ready_d = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            StRun: begin
                if (req) begin
                    state_d     = StHold;
                    hold_cnt_d  = '0;
                    rst_out_d   = '1;
                    rst_ready_d = 1'b0;
                    rst_cause_d = src_cause;
                end
            end

            default: begin
                state_d     = StHold;
                hold_cnt_d  = '0;
                rst_out_d   = '1;
                rst_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pll_meta_q  <= 1'b0;
            pll_sync_q  <= 1'b0;
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            btn_deb_q   <= 1'b0;
            deb_cnt_q   <= '0;
            pll_seen_q  <= 1'b0;
            state_q     <= StHold;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            stage_q     <= '0;
            rst_out_q   <= '1;
            rst_ready_q <= 1'b0;
            rst_cause_q <= 4'b0001;
        end else begin
            pll_meta_q  <= pll_meta_d;
            pll_sync_q  <= pll_sync_d;
            btn_meta_q  <= btn_meta_d;
            btn_sync_q  <= btn_sync_d;
            btn_deb_q   <= btn_deb_d;
            deb_cnt_q   <= deb_cnt_d;
            pll_seen_q  <= pll_seen_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            stage_q     <= stage_d;
            rst_out_q   <= rst_out_d;
            rst_ready_q <= rst_ready_d;
            rst_cause_q <= rst_cause_d;
        end
    end

    assign bus.rstOut   = rst_out_q;
    assign bus.rstReady = rst_ready_q;
    assign bus.rstCause = rst_cause_q;
    assign bus.stateOut = state_q;

endmodule

// File: tb/tb_reset_sequencer_staged.sv
// Self-checking bench for reset_sequencer_staged (NCH=3, HOLD_CYCLES=8, STAGE_GAP=2,
// DEB_CYCLES=4). A driver pushes the expected post-edge outputs into a queue each cycle; a
// monitor pops and compares after every clock edge and right after an async reset assertion.
// The reference model tracks the number of consecutive request-free edges and derives the
// release stage from it arithmetically.
module tb_reset_sequencer_staged;

    localparam int unsigned NCH         = 3;
    localparam int unsigned HOLD_W      = 16;
    localparam int unsigned HOLD_CYCLES = 8;
    localparam int unsigned STAGE_GAP   = 2;
    localparam int unsigned DEB_CYCLES  = 4;

    typedef struct packed {
        logic [NCH-1:0] rst_out;
        logic           ready;
        logic [3:0]     cause;
        logic [1:0]     state;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    reset_sequencer_staged_if #(.NCH(NCH)) bus ();

    reset_sequencer_staged #(
        .NCH         (NCH),
        .HOLD_W      (HOLD_W),
        .HOLD_CYCLES (HOLD_CYCLES),
        .STAGE_GAP   (STAGE_GAP),
        .DEB_CYCLES  (DEB_CYCLES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int       m_since;     // consecutive request-free edges
    bit [3:0] m_cause;
    bit       m_seen;      // lock observed since reset
    bit       m_deb;
    int       m_run;
    bit       pll_dl[$];
    bit       btn_dl[$];
    bit       release_pending = 1'b0;

    function automatic void model_reset();
        m_since = 0;
        m_cause = 4'b0001;
        m_seen  = 1'b0;
        m_deb   = 1'b0;
        m_run   = 0;
        pll_dl  = '{1'b0, 1'b0};
        btn_dl  = '{1'b0, 1'b0};
    endfunction

    function automatic void model_step(input bit pll, input bit btn, input bit sw);
        bit       ps, bs, deb_old, req;
        bit [3:0] act;
        ps = pll_dl.pop_front();
        pll_dl.push_back(pll);
        bs = btn_dl.pop_front();
        btn_dl.push_back(btn);
        deb_old = m_deb;
        req = !ps || deb_old || sw;
        if (bs != m_deb) begin
            m_run++;
            if (m_run == int'(DEB_CYCLES)) begin
                m_deb = !m_deb;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        if (req) begin
            act = {sw, deb_old, (!ps && m_seen), 1'b0};
            if (m_since >= int'(HOLD_CYCLES)) m_cause = act;
            else m_cause = m_cause | act;
            m_since = 0;
        end else if (m_since < 1000000) begin
            m_since++;
        end
        if (ps) m_seen = 1'b1;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        int   k;
        if (m_since < int'(HOLD_CYCLES)) k = 0;
        else k = 1 + (m_since - int'(HOLD_CYCLES)) / int'(STAGE_GAP);
        if (k > int'(NCH)) k = NCH;
        for (int i = 0; i < int'(NCH); i++) e.rst_out[i] = (i >= k);
        e.ready = (k == int'(NCH));
        e.cause = m_cause;
        e.state = (k == 0) ? 2'd0 : ((k == int'(NCH)) ? 2'd2 : 2'd1);
        return e;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        checks++;
        if (bus.rstOut !== e.rst_out) begin
            errors++;
            $display("FAIL %s rstOut got %b want %b t=%0t", tag, bus.rstOut, e.rst_out, $time);
        end
        checks++;
        if (bus.rstReady !== e.ready) begin
            errors++;
            $display("FAIL %s rstReady got %b want %b t=%0t", tag, bus.rstReady, e.ready, $time);
        end
        checks++;
        if (bus.rstCause !== e.cause) begin
            errors++;
            $display("FAIL %s rstCause got %b want %b t=%0t", tag, bus.rstCause, e.cause, $time);
        end
        checks++;
        if (bus.stateOut !== e.state) begin
            errors++;
            $display("FAIL %s stateOut got %0d want %0d t=%0t", tag, bus.stateOut, e.state, $time);
        end
    endtask

    // Fixed expectations for the power-on release timeline.
    task automatic dchk(input string tag, input logic [NCH-1:0] o, input logic r);
        checks++;
        if (bus.rstOut !== o || bus.rstReady !== r || bus.rstCause !== 4'b0001) begin
            errors++;
            $display("FAIL %s got out=%b rdy=%b cause=%b want out=%b rdy=%b cause=0001",
                     tag, bus.rstOut, bus.rstReady, bus.rstCause, o, r);
        end
    endtask

    // One clock cycle of stimulus; inputs change on the falling edge.
    task automatic cycle(input bit pll, input bit btn, input bit sw);
        @(negedge clock);
        if (release_pending) begin
            reset = 1'b1;
            release_pending = 1'b0;
        end
        bus.pllLocked   = pll;
        bus.extResetReq = btn;
        bus.swResetReq  = sw;
        if (reset) model_step(pll, btn, sw);
        else model_reset();
        exp_q.push_back(model_expect());
    endtask

    // Assert reset between edges; the monitor checks the outputs right away.
    task automatic async_reset(input int low_cycles);
        @(posedge clock);
        #2;
        model_reset();
        exp_q.push_back(model_expect());
        reset = 1'b0;
        repeat (low_cycles) cycle(1'b1, 1'b0, 1'b0);
        release_pending = 1'b1;
    endtask

    task automatic quiet_until_release();
        for (int g = 0; g < 100 && m_since != int'(HOLD_CYCLES) + 1; g++) cycle(1'b1, 1'b0, 1'b0);
    endtask

    // Monitors
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) check_out("edge", exp_q.pop_front());
        end
    end

    initial begin
        forever begin
            @(negedge reset);
            #1;
            if (exp_q.size() > 0) check_out("async", exp_q.pop_front());
        end
    end

    initial begin
        int pll_low;
        int btn_high;
        bit sw;
        pll_low  = 0;
        btn_high = 0;
        reset           = 1'b0;
        bus.pllLocked   = 1'b1;
        bus.extResetReq = 1'b0;
        bus.swResetReq  = 1'b0;
        model_reset();

        // Power-on with lock held high; reset released before edge 1.
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        release_pending = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            cycle(1'b1, 1'b0, 1'b0);
            @(posedge clock);
            #2;
            case (e)
                9:  dchk("po_e9", 3'b111, 1'b0);
                10: dchk("po_e10", 3'b110, 1'b0);
                11: dchk("po_e11", 3'b110, 1'b0);
                12: dchk("po_e12", 3'b100, 1'b0);
                13: dchk("po_e13", 3'b100, 1'b0);
                14: dchk("po_e14", 3'b000, 1'b1);
                default: ;
            endcase
        end

        // PLL loss in RUN, then restore.
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        repeat (20) cycle(1'b1, 1'b0, 1'b0);

        // Software pulse in RUN.
        cycle(1'b1, 1'b0, 1'b1);
        repeat (20) cycle(1'b1, 1'b0, 1'b0);

        // Button glitches (2 cycles) must not reset; then a long press.
        repeat (2) begin
            repeat (2) cycle(1'b1, 1'b1, 1'b0);
            repeat (2) cycle(1'b1, 1'b0, 1'b0);
        end
        repeat (8) cycle(1'b1, 1'b0, 1'b0);
        repeat (30) cycle(1'b1, 1'b1, 1'b0);
        repeat (25) cycle(1'b1, 1'b0, 1'b0);

        // PLL loss and software request land on the same edge during RELEASE.
        quiet_until_release();
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (20) cycle(1'b1, 1'b0, 1'b0);

        // Async reset during RELEASE.
        quiet_until_release();
        async_reset(2);
        repeat (20) cycle(1'b1, 1'b0, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 2500; i++) begin
            if (pll_low == 0 && $urandom_range(0, 179) == 0) pll_low = $urandom_range(1, 6);
            if (btn_high == 0 && $urandom_range(0, 129) == 0) btn_high = $urandom_range(1, 9);
            sw = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 699) == 0) async_reset($urandom_range(1, 3));
            cycle(pll_low == 0, btn_high != 0, sw);
            if (pll_low > 0) pll_low--;
            if (btn_high > 0) btn_high--;
        end

        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        @(posedge clock);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
